// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: main register M drives the outputs from flops,
// optional skid register S decouples in_ready from out_ready (SKID=1).
module pipe_stage_elastic #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_m_valid, r_s_valid, r_in_ready;
    logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl;
    logic [DATA_W-1:0] r_m_data, r_s_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_m_valid_nxt, w_s_valid_nxt;
    logic [CTRL_W-1:0] w_m_ctrl_nxt, w_s_ctrl_nxt;
    logic [DATA_W-1:0] w_m_data_nxt, w_s_data_nxt;
    logic              w_in_ready, w_accept, w_pop;

    // The skid variant exposes only the flop; the single-entry variant lets a pop free the slot.
    assign w_in_ready = (SKID != 0) ? r_in_ready : (!r_m_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_pop      = r_m_valid && out_ready;

    always_comb begin
        // NOTE: every next-state net gets a default first, so no path can infer a latch.
        w_m_valid_nxt = r_m_valid;
        w_m_ctrl_nxt  = r_m_ctrl;
        w_m_data_nxt  = r_m_data;
        w_s_valid_nxt = r_s_valid;
        w_s_ctrl_nxt  = r_s_ctrl;
        w_s_data_nxt  = r_s_data;
        if (flush) begin
            w_m_valid_nxt = 1'b0;
            w_m_ctrl_nxt  = '0;
            w_m_data_nxt  = '0;
            w_s_valid_nxt = 1'b0;
            w_s_ctrl_nxt  = '0;
            w_s_data_nxt  = '0;
        end else if (SKID != 0) begin
            if (!r_m_valid || w_pop) begin
                // M frees up: the older skid entry wins over a new input.
                if (r_s_valid) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_ctrl_nxt  = r_s_ctrl;
                    w_m_data_nxt  = r_s_data;
                    w_s_valid_nxt = 1'b0;
                    w_s_ctrl_nxt  = '0;
                    w_s_data_nxt  = '0;
                end else if (w_accept) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_ctrl_nxt  = in_ctrl;
                    w_m_data_nxt  = in_data;
                end else begin
                    w_m_valid_nxt = 1'b0;
                    w_m_ctrl_nxt  = '0;
                    w_m_data_nxt  = '0;
                end
            end else if (w_accept) begin
                w_s_valid_nxt = 1'b1;
                w_s_ctrl_nxt  = in_ctrl;
                w_s_data_nxt  = in_data;
            end
        end else begin
            if (w_accept) begin
                w_m_valid_nxt = 1'b1;
                w_m_ctrl_nxt  = in_ctrl;
                w_m_data_nxt  = in_data;
            end else if (w_pop) begin
                w_m_valid_nxt = 1'b0;
                w_m_ctrl_nxt  = '0;
                w_m_data_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values together.
        if (!rst_n) begin
            r_m_valid   <= 1'b0;
            r_m_ctrl    <= '0;
            r_m_data    <= '0;
            r_s_valid   <= 1'b0;
            r_s_ctrl    <= '0;
            r_s_data    <= '0;
            r_in_ready  <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            r_m_valid  <= w_m_valid_nxt;
            r_m_ctrl   <= w_m_ctrl_nxt;
            r_m_data   <= w_m_data_nxt;
            r_s_valid  <= w_s_valid_nxt;
            r_s_ctrl   <= w_s_ctrl_nxt;
            r_s_data   <= w_s_data_nxt;
            r_in_ready <= !w_s_valid_nxt;
            if (r_m_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_m_valid;
    assign out_ctrl  = r_m_ctrl;
    assign out_data  = r_m_data;
    assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and random checks of pipe_stage_elastic, skid (SKID=1) and
// single-entry (SKID=0) instances driven by the same stimulus.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;

    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_out_ctrl;
    logic [31:0] s_out_data;
    logic [1:0]  s_occ;
    logic [3:0]  s_stall;

    logic        z_in_ready, z_out_valid;
    logic [7:0]  z_out_ctrl;
    logic [31:0] z_out_data;
    logic [1:0]  z_occ;
    logic [3:0]  z_stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] q_s[$];
    logic [39:0] q_z[$];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occ), .stall_cnt(s_stall)
    );

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(4)) u_one (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
        .occupancy(z_occ), .stall_cnt(z_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 8'hEE; in_data = 32'hDEAD_BEEF;
        step(); step();
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", s_out_valid); end
        n_checks++; if (s_out_ctrl !== 8'h0) begin n_fail++; $display("FAIL reset_ctrl got=%0h exp=0", s_out_ctrl); end
        n_checks++; if (s_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%0h exp=0", s_out_data); end
        n_checks++; if (s_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", s_occ); end
        n_checks++; if (s_stall !== 4'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", s_stall); end
        n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", s_in_ready); end
        n_checks++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_skid0 got=%0h exp=1", z_in_ready); end
        n_checks++; if (z_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_skid0 got=%0h exp=0", z_out_valid); end
        rst_n = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0]  c;
        logic [31:0] d;
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            c = 8'(i);
            d = 32'(i) << 12;
            in_valid = 1'b1; in_ctrl = c; in_data = d;
            step();
            n_checks++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%0h exp=1", i, s_out_valid); end
            n_checks++; if (s_out_ctrl !== c) begin n_fail++; $display("FAIL stream_ctrl[%0d] got=%0h exp=%0h", i, s_out_ctrl, c); end
            n_checks++; if (s_out_data !== d) begin n_fail++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, s_out_data, d); end
            n_checks++; if (s_occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, s_occ); end
            n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got=%0h exp=1", i, s_in_ready); end
            n_checks++; if (z_out_data !== d) begin n_fail++; $display("FAIL stream_data_skid0[%0d] got=%0h exp=%0h", i, z_out_data, d); end
        end
        in_valid = 1'b0; in_ctrl = 8'hFF; in_data = 32'hFFFF_FFFF;
        step();
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got=%0h exp=0", s_out_valid); end
        n_checks++; if (s_out_ctrl !== 8'h0) begin n_fail++; $display("FAIL bubble_ctrl got=%0h exp=0", s_out_ctrl); end
        n_checks++; if (s_out_data !== 32'h0) begin n_fail++; $display("FAIL bubble_data got=%0h exp=0", s_out_data); end
        n_checks++; if (s_occ !== 2'd0) begin n_fail++; $display("FAIL bubble_occ got=%0d exp=0", s_occ); end
        n_checks++; if (z_out_data !== 32'h0) begin n_fail++; $display("FAIL bubble_data_skid0 got=%0h exp=0", z_out_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'hA1; in_data = 32'hAAAA_0001;
        step();
        n_checks++; if (s_occ !== 2'd1) begin n_fail++; $display("FAIL bp_occ_a got=%0d exp=1", s_occ); end
        n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a got=%0h exp=1", s_in_ready); end
        n_checks++; if (s_out_ctrl !== 8'hA1) begin n_fail++; $display("FAIL bp_ctrl_a got=%0h exp=a1", s_out_ctrl); end
        in_ctrl = 8'hB2; in_data = 32'hBBBB_0002;
        step();
        n_checks++; if (s_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ_b got=%0d exp=2", s_occ); end
        n_checks++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_b got=%0h exp=0", s_in_ready); end
        n_checks++; if (s_out_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL bp_head_a got=%0h exp=aaaa0001", s_out_data); end
        n_checks++; if (z_out_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL bp_head_a_skid0 got=%0h exp=aaaa0001", z_out_data); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_registered got=%0h exp=0", s_in_ready); end
        step();
        n_checks++; if (s_out_data !== 32'hBBBB_0002) begin n_fail++; $display("FAIL bp_head_b got=%0h exp=bbbb0002", s_out_data); end
        n_checks++; if (s_out_ctrl !== 8'hB2) begin n_fail++; $display("FAIL bp_ctrl_b got=%0h exp=b2", s_out_ctrl); end
        n_checks++; if (s_occ !== 2'd1) begin n_fail++; $display("FAIL bp_occ_drain got=%0d exp=1", s_occ); end
        n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%0h exp=1", s_in_ready); end
        n_checks++; if (z_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_bubble_skid0 got=%0h exp=0", z_out_valid); end
        step();
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%0h exp=0", s_out_valid); end
        n_checks++; if (s_occ !== 2'd0) begin n_fail++; $display("FAIL bp_occ_empty got=%0d exp=0", s_occ); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h11; in_data = 32'h1111_1111;
        step();
        in_ctrl = 8'h22; in_data = 32'h2222_2222;
        step();
        n_checks++; if (s_occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got=%0d exp=2", s_occ); end
        flush = 1'b1; in_ctrl = 8'hCC; in_data = 32'hCCCC_0000;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%0h exp=0", s_out_valid); end
        n_checks++; if (s_out_ctrl !== 8'h0) begin n_fail++; $display("FAIL flush_ctrl got=%0h exp=0", s_out_ctrl); end
        n_checks++; if (s_out_data !== 32'h0) begin n_fail++; $display("FAIL flush_data got=%0h exp=0", s_out_data); end
        n_checks++; if (s_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ got=%0d exp=0", s_occ); end
        n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%0h exp=1", s_in_ready); end
        n_checks++; if (z_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_skid0 got=%0h exp=0", z_out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost[%0d] got=%0h exp=0", i, s_out_valid); end
        end
    endtask

    task automatic test_skid0_replace();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 32'h5A5A_5A5A;
        step();
        in_ctrl = 8'h6B; in_data = 32'h6B6B_6B6B;
        #1;
        n_checks++; if (z_in_ready !== 1'b0) begin n_fail++; $display("FAIL skid0_ready_blocked got=%0h exp=0", z_in_ready); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL skid0_ready_comb got=%0h exp=1", z_in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (z_out_valid !== 1'b1) begin n_fail++; $display("FAIL skid0_replace_valid got=%0h exp=1", z_out_valid); end
        n_checks++; if (z_out_ctrl !== 8'h6B) begin n_fail++; $display("FAIL skid0_replace_ctrl got=%0h exp=6b", z_out_ctrl); end
        n_checks++; if (z_out_data !== 32'h6B6B_6B6B) begin n_fail++; $display("FAIL skid0_replace_data got=%0h exp=6b6b6b6b", z_out_data); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h0D; in_data = 32'h0000_D00D;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        n_checks++; if (s_stall !== 4'd5) begin n_fail++; $display("FAIL stall_count got=%0d exp=5", s_stall); end
        n_checks++; if (z_stall !== 4'd5) begin n_fail++; $display("FAIL stall_count_skid0 got=%0d exp=5", z_stall); end
        repeat (15) step();
        n_checks++; if (s_stall !== 4'd15) begin n_fail++; $display("FAIL stall_saturate got=%0d exp=15", s_stall); end
        n_checks++; if (z_stall !== 4'd15) begin n_fail++; $display("FAIL stall_saturate_skid0 got=%0d exp=15", z_stall); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (s_stall !== 4'd15) begin n_fail++; $display("FAIL stall_after_flush got=%0d exp=15", s_stall); end
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_flush_valid got=%0h exp=0", s_out_valid); end
        in_valid = 1'b1; in_ctrl = 8'h0E; in_data = 32'h0000_E00E;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        n_checks++; if (s_stall !== 4'd0) begin n_fail++; $display("FAIL stall_reset got=%0d exp=0", s_stall); end
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got=%0h exp=0", s_out_valid); end
        n_checks++; if (s_occ !== 2'd0) begin n_fail++; $display("FAIL midreset_occ got=%0d exp=0", s_occ); end
    endtask

    task automatic test_random();
        do_reset();
        q_s.delete();
        q_z.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ctrl   = 8'($urandom);
            in_data   = $urandom;
            @(negedge clk);
            // skid instance against its scoreboard
            n_checks++; if (s_occ !== 2'(q_s.size())) begin n_fail++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, s_occ, q_s.size()); end
            n_checks++; if (s_in_ready !== (q_s.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%0h exp=%0h", cyc, s_in_ready, q_s.size() < 2); end
            n_checks++;
            if (s_out_valid === 1'b1) begin
                if (q_s.size() == 0) begin n_fail++; $display("FAIL rnd_head cyc=%0d got=%0h exp=none", cyc, {s_out_ctrl, s_out_data}); end
                else if ({s_out_ctrl, s_out_data} !== q_s[0]) begin n_fail++; $display("FAIL rnd_head cyc=%0d got=%0h exp=%0h", cyc, {s_out_ctrl, s_out_data}, q_s[0]); end
            end else if ({s_out_ctrl, s_out_data} !== 40'h0) begin
                n_fail++; $display("FAIL rnd_zero cyc=%0d got=%0h exp=0", cyc, {s_out_ctrl, s_out_data});
            end
            if (s_out_valid === 1'b1 && out_ready && q_s.size() > 0) void'(q_s.pop_front());
            if (flush) q_s.delete();
            else if (in_valid && s_in_ready) q_s.push_back({in_ctrl, in_data});
            // single-entry instance against its scoreboard
            n_checks++; if (z_occ !== 2'(q_z.size())) begin n_fail++; $display("FAIL rnd_occ_skid0 cyc=%0d got=%0d exp=%0d", cyc, z_occ, q_z.size()); end
            n_checks++; if (z_in_ready !== (q_z.size() == 0 || out_ready)) begin n_fail++; $display("FAIL rnd_ready_skid0 cyc=%0d got=%0h", cyc, z_in_ready); end
            n_checks++;
            if (z_out_valid === 1'b1) begin
                if (q_z.size() == 0) begin n_fail++; $display("FAIL rnd_head_skid0 cyc=%0d got=%0h exp=none", cyc, {z_out_ctrl, z_out_data}); end
                else if ({z_out_ctrl, z_out_data} !== q_z[0]) begin n_fail++; $display("FAIL rnd_head_skid0 cyc=%0d got=%0h exp=%0h", cyc, {z_out_ctrl, z_out_data}, q_z[0]); end
            end else if ({z_out_ctrl, z_out_data} !== 40'h0) begin
                n_fail++; $display("FAIL rnd_zero_skid0 cyc=%0d got=%0h exp=0", cyc, {z_out_ctrl, z_out_data});
            end
            if (z_out_valid === 1'b1 && out_ready && q_z.size() > 0) void'(q_z.pop_front());
            if (flush) q_z.delete();
            else if (in_valid && z_in_ready) q_z.push_back({in_ctrl, in_data});
            @(posedge clk);
            #1;
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_skid0_replace();
        test_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
